// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
//   state_t    : controller FSM encoding (sweep / normal operation)
//   BYTE_W     : bits per byte lane
//   lane_count : number of byte lanes in a data word
package dmem_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int lane_count(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between a memory client (LSU, fetch unit) and the
// data memory controller.
//   req/we/be/addr/wdata : request, driven by the client (master)
//   ready                : controller can accept a request this cycle
//   rvalid/rdata         : read response pulse and data
//   init_done            : zero sweep finished, memory usable
interface data_ram_ctrl_if
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    localparam int LANES = lane_count(DATA_WIDTH);

    logic                  req;
    logic                  we;
    logic [LANES-1:0]      be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  init_done;

    modport master (
        output req, we, be, addr, wdata,
        input  ready, rvalid, rdata, init_done
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ready, rvalid, rdata, init_done
    );

endinterface

// File: rtl/dmem_array.sv
// Storage core of the data memory: a single-port array with per-byte write
// enables and a registered read port. No reset, so it maps onto block RAM.
//   clk   : clock
//   en    : port enable (one access per cycle)
//   we    : 1 = write, 0 = read
//   be    : byte-lane write enables
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered, updated only on an enabled read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              en,
    input  logic                              we,
    input  logic [lane_count(DATA_WIDTH)-1:0] be,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH-1:0]             rdata
);
    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) begin
                        mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Synchronous single-port data memory with req/ready handshake, byte write
// enables, read latency of 1 or 2 cycles and an optional post-reset zero sweep.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (array contents are kept)
//   bus   : slave side of data_ram_ctrl_if (request in, response out)
module data_ram_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    data_ram_ctrl_if.slave  bus
);
    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Extra counter bit keeps the last sweep address distinct from "done".
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic                  sweep_en;
    logic                  run;
    logic                  accept;
    logic                  rd_accept;

    logic                  mem_en;
    logic                  mem_we;
    logic [LANES-1:0]      mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rdata_p0;
    logic                  vld_p0;
    logic                  vld_out;
    logic [DATA_WIDTH-1:0] data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Without INIT_ZERO the INIT state lasts a single edge and writes nothing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_en  = 1'b0;
        case (state)
            ST_INIT: begin
                if (INIT_ZERO != 0) begin
                    sweep_en = 1'b1;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_nxt = ST_RUN;
                    end
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign run       = (state == ST_RUN);
    assign accept    = bus.req && run;
    assign rd_accept = accept && !bus.we;

    // The sweep owns the array port while in INIT; requests are ignored.
    assign mem_en    = sweep_en || accept;
    assign mem_we    = sweep_en || (accept && bus.we);
    assign mem_be    = sweep_en ? '1 : bus.be;
    assign mem_addr  = sweep_en ? cnt[ADDR_WIDTH-1:0] : bus.addr;
    assign mem_wdata = sweep_en ? '0 : bus.wdata;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rdata_p0)
    );

    // ---- stage p0: array output register, valid flag tracks it ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_accept;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  vld_p1;
        logic [DATA_WIDTH-1:0] rdata_p1;

        // ---- stage p1: optional output register for timing ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
            end
        end

        always_ff @(posedge clk) begin
            rdata_p1 <= rdata_p0;
        end

        assign vld_out  = vld_p1;
        assign data_out = rdata_p1;
    end else begin : g_lat1
        assign vld_out  = vld_p0;
        assign data_out = rdata_p0;
    end

    // Data registers carry no reset; masking keeps rdata clean and X-free.
    assign bus.ready     = run;
    assign bus.init_done = run;
    assign bus.rvalid    = vld_out;
    assign bus.rdata     = vld_out ? data_out : '0;

endmodule

// File: tb/tb_data_ram_ctrl.sv
module tb_data_ram_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int HIST  = 4096;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [3:0]    be    = '0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;

    always #5 clk = ~clk;

    data_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
    data_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();
    data_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();

    assign b1.req = req;  assign b1.we = we;  assign b1.be = be;  assign b1.addr = addr;  assign b1.wdata = wdata;
    assign b2.req = req;  assign b2.we = we;  assign b2.be = be;  assign b2.addr = addr;  assign b2.wdata = wdata;
    assign b0.req = req;  assign b0.we = we;  assign b0.be = be;  assign b0.addr = addr;  assign b0.wdata = wdata;

    data_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_ZERO(1))
        dut_l1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    data_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_ZERO(1))
        dut_l2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    data_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_ZERO(0))
        dut_nz (.clk(clk), .rst_n(rst_n), .bus(b0));

    int errors = 0;
    int checks = 0;

    // Rising edges seen so far; the reference model is indexed by edge number.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int          rel_edge = 0;
    logic [31:0] model_mem [DEPTH];
    bit          acc_rd  [HIST];
    logic [31:0] acc_dat [HIST];

    // The memory is usable DEPTH edges after reset release.
    function automatic bit model_ready(input int e);
        return rst_n && (e >= rel_edge + DEPTH);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < HIST; i++) begin
            acc_rd[i]  = 1'b0;
            acc_dat[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Called at a falling edge: drive one request, predict its effect at the
    // next rising edge, and return at the following falling edge.
    task automatic drive(input bit r, input bit w, input logic [3:0] b,
                         input logic [AW-1:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
        acc_rd[edge_n+1]  = 1'b0;
        acc_dat[edge_n+1] = '0;
        if (r && model_ready(edge_n)) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
            end else begin
                acc_rd[edge_n+1]  = 1'b1;
                acc_dat[edge_n+1] = model_mem[a];
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit exp;
        repeat (2) @(negedge clk);
        checks++;
        if (b1.ready !== 1'b0 || b1.init_done !== 1'b0 || b1.rvalid !== 1'b0 || b1.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_l1 ready=%b done=%b rvalid=%b rdata=%h want all zero", b1.ready, b1.init_done, b1.rvalid, b1.rdata);
        end
        checks++;
        if (b2.ready !== 1'b0 || b2.init_done !== 1'b0 || b2.rvalid !== 1'b0 || b2.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_l2 ready=%b done=%b rvalid=%b rdata=%h want all zero", b2.ready, b2.init_done, b2.rvalid, b2.rdata);
        end
        checks++;
        if (b0.ready !== 1'b0 || b0.init_done !== 1'b0 || b0.rvalid !== 1'b0 || b0.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_nz ready=%b done=%b rvalid=%b rdata=%h want all zero", b0.ready, b0.init_done, b0.rvalid, b0.rdata);
        end
        clear_model();
        rst_n = 1'b1;
        rel_edge = edge_n;
        // req held high during the sweep, alternating writes of all-ones and reads.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, i[0], 4'hF, 4'h7, 32'hFFFF_FFFF);
            exp = (i == DEPTH);
            checks++;
            if (b1.ready !== exp || b1.init_done !== exp || b2.ready !== exp || b2.init_done !== exp
                || b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0) begin
                errors++;
                $display("FAIL sweep_cycle%0d ready=%b/%b done=%b/%b rvalid=%b/%b want ready=done=%b rvalid=0",
                         i, b1.ready, b2.ready, b1.init_done, b2.init_done, b1.rvalid, b2.rvalid, exp);
            end
            checks++;
            if (b0.ready !== 1'b1 || b0.init_done !== 1'b1) begin
                errors++;
                $display("FAIL nozero_ready cycle%0d ready=%b done=%b want 1/1", i, b0.ready, b0.init_done);
            end
        end
        drive(1'b1, 1'b0, 4'h0, 4'h7, 32'h0);
        checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== 32'h0 || b2.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL first_read_l1 rvalid=%b rdata=%h l2_rvalid=%b want 1/00000000/0", b1.rvalid, b1.rdata, b2.rvalid);
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checks++;
        if (b2.rvalid !== 1'b1 || b2.rdata !== 32'h0 || b1.rvalid !== 1'b0 || b1.rdata !== 32'h0) begin
            errors++;
            $display("FAIL first_read_l2 rvalid=%b rdata=%h l1_rvalid=%b l1_rdata=%h want 1/00000000/0/00000000",
                     b2.rvalid, b2.rdata, b1.rvalid, b1.rdata);
        end
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 1'b1, 4'hF, 4'h3, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 4'h5, 4'h3, 32'h1122_3344);
        checks++;
        if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvalid rvalid=%b/%b want 0/0", b1.rvalid, b2.rvalid);
        end
        drive(1'b1, 1'b0, 4'h0, 4'h3, 32'h0);
        checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== 32'hDE22_BE44) begin
            errors++;
            $display("FAIL byte_en_l1 rvalid=%b rdata=%h want 1/de22be44", b1.rvalid, b1.rdata);
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checks++;
        if (b2.rvalid !== 1'b1 || b2.rdata !== 32'hDE22_BE44 || b1.rvalid !== 1'b0 || b1.rdata !== 32'h0) begin
            errors++;
            $display("FAIL byte_en_l2 rvalid=%b rdata=%h l1=%b/%h want 1/de22be44 l1 0/00000000",
                     b2.rvalid, b2.rdata, b1.rvalid, b1.rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2;
        bit v1, v2;
        for (int k = 1; k <= 3; k++) drive(1'b1, 1'b1, 4'hF, AW'(k), 32'hA0 + k);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1'b1, 1'b0, 4'h0, AW'(k + 1), 32'h0);
            else       drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
            v1 = (k < 3);
            e1 = v1 ? 32'hA1 + k : 32'h0;
            v2 = (k >= 1 && k < 4);
            e2 = v2 ? 32'hA0 + k : 32'h0;
            checks++;
            if (b1.rvalid !== v1 || b1.rdata !== e1) begin
                errors++;
                $display("FAIL b2b_l1 step%0d rvalid=%b rdata=%h want %b/%h", k, b1.rvalid, b1.rdata, v1, e1);
            end
            checks++;
            if (b2.rvalid !== v2 || b2.rdata !== e2) begin
                errors++;
                $display("FAIL b2b_l2 step%0d rvalid=%b rdata=%h want %b/%h", k, b2.rvalid, b2.rdata, v2, e2);
            end
        end
    endtask

    task automatic test_raw();
        drive(1'b1, 1'b1, 4'hF, 4'hF, 32'h5);
        drive(1'b1, 1'b0, 4'h0, 4'hF, 32'h0);
        checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== 32'h5) begin
            errors++;
            $display("FAIL raw_l1 rvalid=%b rdata=%h want 1/00000005", b1.rvalid, b1.rdata);
        end
        drive(1'b1, 1'b1, 4'h0, 4'hF, 32'hFFFF_FFFF);
        checks++;
        if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b1 || b2.rdata !== 32'h5) begin
            errors++;
            $display("FAIL be0_write l1_rvalid=%b l2=%b/%h want 0 and 1/00000005", b1.rvalid, b2.rvalid, b2.rdata);
        end
        drive(1'b1, 1'b0, 4'h0, 4'hF, 32'h0);
        checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== 32'h5 || b2.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL be0_read_l1 rvalid=%b rdata=%h l2_rvalid=%b want 1/00000005/0", b1.rvalid, b1.rdata, b2.rvalid);
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checks++;
        if (b2.rvalid !== 1'b1 || b2.rdata !== 32'h5) begin
            errors++;
            $display("FAIL be0_read_l2 rvalid=%b rdata=%h want 1/00000005", b2.rvalid, b2.rdata);
        end
    endtask

    task automatic test_random();
        bit          ev1, ev2;
        logic [31:0] ed1, ed2;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
                  AW'($urandom), $urandom);
            ev1 = acc_rd[edge_n];
            ed1 = ev1 ? acc_dat[edge_n] : 32'h0;
            ev2 = acc_rd[edge_n-1];
            ed2 = ev2 ? acc_dat[edge_n-1] : 32'h0;
            checks++;
            if (b1.rvalid !== ev1 || b1.rdata !== ed1 || b1.ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_l1 n=%0d rvalid=%b rdata=%h ready=%b want %b/%h/1", n, b1.rvalid, b1.rdata, b1.ready, ev1, ed1);
            end
            checks++;
            if (b2.rvalid !== ev2 || b2.rdata !== ed2 || b2.ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_l2 n=%0d rvalid=%b rdata=%h ready=%b want %b/%h/1", n, b2.rvalid, b2.rdata, b2.ready, ev2, ed2);
            end
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset_midflight();
        bit exp;
        drive(1'b1, 1'b1, 4'hF, 4'h3, 32'h1234_5678);
        drive(1'b1, 1'b1, 4'hF, 4'h9, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 4'h0, 4'h9, 32'h0);
        // Read to addr 9 is still in the second stage of the latency-2 instance.
        req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (b1.rvalid !== 1'b0 || b1.rdata !== 32'h0 || b2.rvalid !== 1'b0 || b2.rdata !== 32'h0
            || b1.ready !== 1'b0 || b2.init_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset rvalid=%b/%b rdata=%h/%h ready=%b done=%b want all zero",
                     b1.rvalid, b2.rvalid, b1.rdata, b2.rdata, b1.ready, b2.init_done);
        end
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel_edge = edge_n;
        for (int i = 1; i <= DEPTH / 2; i++) begin
            drive(1'b1, 1'b0, 4'h0, 4'h9, 32'h0);
            checks++;
            if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0 || b1.ready !== 1'b0 || b2.ready !== 1'b0) begin
                errors++;
                $display("FAIL half_sweep cycle%0d rvalid=%b/%b ready=%b/%b want 0", i, b1.rvalid, b2.rvalid, b1.ready, b2.ready);
            end
        end
        req = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel_edge = edge_n;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b0, 4'h0, 4'h9, 32'h0);
            exp = (i == DEPTH);
            checks++;
            if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0 || b1.init_done !== exp || b2.init_done !== exp) begin
                errors++;
                $display("FAIL resweep cycle%0d rvalid=%b/%b done=%b/%b want 0/0 done=%b",
                         i, b1.rvalid, b2.rvalid, b1.init_done, b2.init_done, exp);
            end
        end
        drive(1'b1, 1'b0, 4'h0, 4'h9, 32'h0);
        checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== 32'h0) begin
            errors++;
            $display("FAIL cleared9_l1 rvalid=%b rdata=%h want 1/00000000", b1.rvalid, b1.rdata);
        end
        drive(1'b1, 1'b0, 4'h0, 4'h3, 32'h0);
        checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== 32'h0 || b2.rvalid !== 1'b1 || b2.rdata !== 32'h0) begin
            errors++;
            $display("FAIL cleared3 l1=%b/%h l2=%b/%h want 1/00000000 both", b1.rvalid, b1.rdata, b2.rvalid, b2.rdata);
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checks++;
        if (b2.rvalid !== 1'b1 || b2.rdata !== 32'h0 || b1.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cleared3_l2 rvalid=%b rdata=%h l1_rvalid=%b want 1/00000000/0", b2.rvalid, b2.rdata, b1.rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_raw();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout errors=%0d checks=%0d simulation did not complete", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Parametrised, synchronous, single-port data memory for the CPU data path. Next generation of the 16x32 combinational RAM.
- Adds a clock, a req/ready handshake, per-byte write enables, and a configurable read latency of 1 or 2 cycles.
- After reset, an optional hardware sweep clears every word to zero. The LSU drives it directly; the instruction memory can reuse it with writes tied off.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, word-address width; DEPTH = 2**ADDR_WIDTH words, exactly, fully decoded.
- READ_LATENCY, 1, cycles from read accept to rvalid; legal values are 1 and 2.
- INIT_ZERO, 1, when 1, zero-fill the whole array after every reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request valid.
- we  in  1  1 = write, 0 = read; sampled with req.
- be  in  DATA_WIDTH/8  byte enables for writes; be[i] covers wdata[8i+7:8i].
- addr  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- ready  out  1  high when a request can be accepted this cycle.
- rvalid  out  1  one-cycle pulse; rdata is valid while it is high.
- rdata  out  DATA_WIDTH  read data; all-zero whenever rvalid is low.
- init_done  out  1  high once the zero sweep completes (or immediately when INIT_ZERO=0).

Behaviour:
- Reset (rst_n low), asynchronous:
  - ready=0, rvalid=0, rdata=0, init_done=0.
  - Read pipeline flushed; sweep counter = 0.
  - Array contents are not reset by rst_n itself.
- FSM states are INIT and RUN.
- First edge after rst_n rises:
  - INIT_ZERO=1: enter INIT.
  - INIT_ZERO=0: enter RUN with init_done=1.
- INIT state:
  - Each cycle writes 0 to mem[cnt], then cnt increments.
  - When cnt = DEPTH-1 has been written, next state is RUN and init_done=1. Duration is DEPTH cycles.
  - ready=0 throughout; req is ignored and no write occurs.
- RUN state: ready=1 every cycle.
- Accept: a request is accepted on a rising edge where req && ready. At most one operation per cycle.
- Write (we=1):
  - At the accept edge, mem[addr] byte i takes wdata byte i for each be[i]=1; other bytes are unchanged.
  - be all zero is accepted as a no-op.
  - No rvalid is produced.
- Read (we=0):
  - READ_LATENCY=1: rvalid=1 and rdata=mem[addr] in the cycle after the accept edge.
  - READ_LATENCY=2: one extra register stage; rvalid follows the accept edge by 2 cycles.
  - Back-to-back reads give back-to-back rvalid pulses, in order. Throughput is 1 operation per cycle.
- Read after write to the same address, next cycle: returns the newly written data (write-first ordering across cycles).
- Reset mid-operation:
  - In-flight reads are dropped; no rvalid after reset.
  - With INIT_ZERO=1, the sweep restarts from address 0 even if a previous sweep was partial.
- Width rules:
  - addr uses all ADDR_WIDTH bits; there is no out-of-range word and no wrap.
  - Sweep counter is ADDR_WIDTH+1 bits, so the terminal count is unambiguous.
- No X on outputs after reset release; rdata is forced to zero, not held, when rvalid is low.

Decomposition:
- Shared package dmem_pkg:
  - FSM state encoding (ST_INIT, ST_RUN).
  - Byte-width constant BYTE_W=8.
  - Function for lane count (DATA_WIDTH/8).
- One natural sub-module, dmem_array:
  - Pure clocked storage with byte-enabled write and registered read, no reset.
  - Keeps the array inferable as block RAM.
  - data_ram_ctrl wraps it with the FSM, sweep counter, handshake mux, and latency pipe.

Test Plan:
- Reset with INIT_ZERO=1, ADDR_WIDTH=4: ready stays 0 and init_done rises after exactly 16 cycles. A subsequent read of addr 0x7 returns 0x00000000 with rvalid one cycle later.
- Write 0xDEADBEEF to addr 0x3 with be=4'b1111, then write 0x11223344 with be=4'b0101. Read addr 0x3 -> rdata=0xDE22BE44.
- Reads of addr 1,2,3 on consecutive cycles, after writes of 0xA1/0xA2/0xA3, with READ_LATENCY=2 -> rvalid high for 3 consecutive cycles starting 2 cycles after the first accept, data A1,A2,A3 in order.
- Write 0x5 to addr 0xF, read addr 0xF on the very next cycle -> rdata=0x5. Write with be=0 to addr 0xF, then read -> still 0x5 and no rvalid on the write.
- req held high during INIT -> no writes land and no rvalid. First accept occurs on the first cycle with ready=1.
- rst_n pulsed low with a read in flight and the sweep half done -> rvalid never asserts for the dropped read. The sweep restarts, and init_done rises DEPTH cycles after release.
